alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Sequencing front-end for the `alu` datapath. It accepts one operation per request through a valid/ready handshake and executes it. Logic, arithmetic and bitwise operations go through a single-cycle `alu` instance. Shift operations run on an iterative one-bit-per-cycle shifter. The unit registers the result and flags and returns them through a response valid/ready handshake. It sits between the instruction/issue logic and the `alu`, acting as the initiator that drives the `alu` opcode/operand interface.

## Interface
- `WIDTH`, 4: operand and result width, ≥2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request; high only in IDLE.
- `req_opcode` in 4: opcode from `alu_ops`.
- `req_a` in WIDTH: operand A.
- `req_b` in WIDTH: operand B; also the shift amount for shift ops.
- `req_cin` in 1: carry in.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_y` out WIDTH: result.
- `rsp_cout`, `rsp_overflow`, `rsp_negative`, `rsp_zero` out 1 each: flags.
- `rsp_err` out 1: opcode not defined in `alu_ops`.

## Operation
- **States:**
  - IDLE: `req_ready`=1. On `req_valid`, capture opcode and operands.
    - Shift op: go to SHIFT.
    - Any other op: go to RESP.
  - SHIFT: one bit per cycle while count>0, then go to RESP.
  - RESP: `rsp_valid`=1. On `rsp_ready`, go to IDLE.
- **Non-shift ops** (NOT/AND/OR/XOR/arithmetic): captured operands drive the `alu` instance. Its y/cout/overflow/negative/zero are registered on the acceptance edge.
- **Shift ops** (LL_SHIFT_OP, LR_SHIFT_OP, AR_SHIFT_OP):
  - count = min(`req_b`, WIDTH).
  - LL: shift left, zero fill.
  - LR: shift right, zero fill.
  - AR: shift right, MSB fill.
- **Shift flags:**
  - cout = last bit shifted out (0 if count=0).
  - overflow=0.
  - negative = y[WIDTH-1].
  - zero = (y==0).
- **Undefined opcode:** y=0, zero=1, other flags 0, `rsp_err`=1. Latency is the same as a non-shift op.
- **Output stability:** response outputs are held stable while `rsp_valid`=1 and `rsp_ready`=0. Outside RESP, they hold the last response.
- **No overlap:** `req_ready`=0 outside IDLE. A request and a response are never in flight together.
- **Reset values:** all outputs 0 except `req_ready`=1. State goes to IDLE.
- **Reset mid-operation:** reset in SHIFT or RESP aborts the operation. The response is discarded, never presented.

## Timing
- Acceptance edge = rising edge where `req_valid`&&`req_ready`.
- Non-shift and undefined ops: `rsp_valid` is high in the cycle after acceptance (latency 1).
- Shift ops: `rsp_valid` is high count+1 cycles after acceptance.
  - count=0 gives latency 1, with y=a.
  - count≥WIDTH takes exactly WIDTH shift cycles.
- Response handshake edge (`rsp_valid`&&`rsp_ready`) returns to IDLE. `req_ready` rises in the following cycle.
- Minimum spacing between accepted requests is 2 cycles.

## Configuration
- Macro: `ALU_EXEC_STICKY_EN`.
- **Defined:** adds three ports.
  - `sticky_clr` in 1.
  - `sticky_overflow` out 1.
  - `sticky_cout` out 1.
- **Sticky behaviour when defined:**
  - Each response handshake ORs `rsp_overflow`/`rsp_cout` into the sticky bits.
  - `sticky_clr` zeroes them.
  - If clear and handshake occur in the same cycle, the result equals that response's flags.
  - Reset value is 0.
- **Not defined:** the ports and registers do not exist. Behaviour is otherwise identical.

## Structure
- Opcode constants come from the existing `alu_ops` package.
- The state enum (IDLE/SHIFT/RESP) is added to `alu_ops` as `exec_state_t`.
- Helper function `is_shift_op(opcode)` is added to `alu_ops`.
- Sub-modules:
  - Existing `alu #(WIDTH)`: one instance.
  - New `alu_iter_shifter`: shift register, down-counter, fill logic.

## Test plan
1. LL_SHIFT_OP, a=0001, b=0001 -> y=0010, cout=0, rsp_valid 2 cycles after acceptance.
2. AR_SHIFT_OP, a=1001, b=0111 -> count capped at 4, y=1111, negative=1, cout=1, rsp_valid 5 cycles after acceptance.
3. XOR_OP, a=1100, b=1010 -> y=0110, zero=0, latency 1. NOT_OP, a=1000 -> y=0111.
4. OR_OP, a=1010, b=0101, with rsp_ready held low 3 cycles -> y=1111 and flags stable, req_ready=0 throughout; after the handshake, req_ready=1 next cycle.
5. LR_SHIFT_OP, a=1000, b=0011, rst pulsed on the 2nd SHIFT cycle -> all outputs 0, req_ready=1, no rsp_valid pulse. Undefined opcode -> rsp_err=1, y=0, zero=1.
6. With `ALU_EXEC_STICKY_EN`: an op with overflow=1, then a clean op -> sticky_overflow stays 1. sticky_clr coincident with a clean response -> 0.

Source files
------------

// File: rtl/alu_ops_pkg.sv
// rtl/alu_ops_pkg.sv - opcode constants, exec FSM state type and opcode helpers
//
// Package alu_ops, shared by alu, alu_iter_shifter and alu_exec_unit.
//   *_OP              4-bit opcode constants (anything above AR_SHIFT_OP is undefined)
//   exec_state_t      IDLE / SHIFT / RESP state of the exec sequencer
//   is_shift_op()     true for the three iterative shift opcodes
//   is_defined_op()   true for every opcode listed here
package alu_ops;

  localparam logic [3:0] ADD_OP      = 4'h0;  // a + b + cin
  localparam logic [3:0] SUB_OP      = 4'h1;  // a - b, cout = no borrow
  localparam logic [3:0] NOT_OP      = 4'h2;
  localparam logic [3:0] AND_OP      = 4'h3;
  localparam logic [3:0] OR_OP       = 4'h4;
  localparam logic [3:0] XOR_OP      = 4'h5;
  localparam logic [3:0] LL_SHIFT_OP = 4'h6;
  localparam logic [3:0] LR_SHIFT_OP = 4'h7;
  localparam logic [3:0] AR_SHIFT_OP = 4'h8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } exec_state_t;

  function automatic logic is_shift_op(input logic [3:0] opcode);
    return (opcode == LL_SHIFT_OP) || (opcode == LR_SHIFT_OP) || (opcode == AR_SHIFT_OP);
  endfunction

  function automatic logic is_defined_op(input logic [3:0] opcode);
    return opcode <= AR_SHIFT_OP;
  endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - single-cycle combinational logic/arithmetic datapath
//
// Ports:
//   opcode   in  4      operation from alu_ops (shift and undefined opcodes give y=0)
//   a, b     in  WIDTH  operands
//   cin      in  1      carry in (ADD_OP only)
//   y        out WIDTH  result
//   cout, overflow, negative, zero  out 1  flags
module alu import alu_ops::*; #(
  parameter int WIDTH = 4
) (
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             overflow,
  output logic             negative,
  output logic             zero
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum      = '0;
    y        = '0;
    cout     = 1'b0;
    overflow = 1'b0;
    case (opcode)
      ADD_OP: begin
        sum      = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
        y        = sum[WIDTH-1:0];
        cout     = sum[WIDTH];
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      end
      SUB_OP: begin
        // two's-complement subtract; carry out set means no borrow
        sum      = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        y        = sum[WIDTH-1:0];
        cout     = sum[WIDTH];
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (y[WIDTH-1] != a[WIDTH-1]);
      end
      NOT_OP:  y = ~a;
      AND_OP:  y = a & b;
      OR_OP:   y = a | b;
      XOR_OP:  y = a ^ b;
      default: y = '0;
    endcase
    negative = y[WIDTH-1];
    zero     = (y == '0);
  end

endmodule

// File: rtl/alu_iter_shifter.sv
// rtl/alu_iter_shifter.sv - iterative one-bit-per-cycle shifter with down-counter
//
// Ports:
//   clk, rst   in  1      clock, async active-high reset
//   load       in  1      capture a, capped amount and opcode
//   step       in  1      perform one shift while the count is non-zero
//   opcode     in  4      LL/LR/AR_SHIFT_OP selects fill rule
//   a          in  WIDTH  value to shift
//   amount     in  WIDTH  requested shift amount, capped at WIDTH
//   y_next     out WIDTH  value after the next one-bit shift
//   cout_next  out 1      bit shifted out by the next shift
//   last       out 1      the next shift is the final one
module alu_iter_shifter import alu_ops::*; #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] amount,
  output logic [WIDTH-1:0] y_next,
  output logic             cout_next,
  output logic             last
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_init;
  logic [3:0]       mode;

  // amounts of WIDTH or more all clear/fill the word completely
  assign cnt_init = (amount >= WIDTH'(WIDTH)) ? CW'(WIDTH) : amount[CW-1:0];
  assign last     = (cnt == CW'(1));

  always_comb begin
    y_next    = sr;
    cout_next = 1'b0;
    case (mode)
      LL_SHIFT_OP: begin
        y_next    = {sr[WIDTH-2:0], 1'b0};
        cout_next = sr[WIDTH-1];
      end
      LR_SHIFT_OP: begin
        y_next    = {1'b0, sr[WIDTH-1:1]};
        cout_next = sr[0];
      end
      AR_SHIFT_OP: begin
        y_next    = {sr[WIDTH-1], sr[WIDTH-1:1]};
        cout_next = sr[0];
      end
      default: begin
        y_next    = sr;
        cout_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr   <= '0;
      cnt  <= '0;
      mode <= '0;
    end else if (load) begin
      sr   <= a;
      cnt  <= cnt_init;
      mode <= opcode;
    end else if (step && (cnt != '0)) begin
      sr  <= y_next;
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - request/response sequencer around alu and alu_iter_shifter
//
// Optional feature macro: ALU_EXEC_STICKY_EN (sticky overflow/carry flags).
// Ports:
//   clk, rst             in  1      clock, async active-high reset
//   req_valid/req_ready  handshake for one operation (ready only in IDLE)
//   req_opcode           in  4      alu_ops opcode
//   req_a, req_b         in  WIDTH  operands; req_b is the shift amount for shifts
//   req_cin              in  1      carry in
//   rsp_valid/rsp_ready  handshake for the registered result
//   rsp_y                out WIDTH  result
//   rsp_cout, rsp_overflow, rsp_negative, rsp_zero  out 1  flags
//   rsp_err              out 1      opcode undefined
//   sticky_clr           in  1      (ALU_EXEC_STICKY_EN) clear sticky flags
//   sticky_overflow, sticky_cout  out 1  (ALU_EXEC_STICKY_EN) accumulated flags
module alu_exec_unit import alu_ops::*; #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_opcode,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_cout,
  output logic             rsp_overflow,
  output logic             rsp_negative,
  output logic             rsp_zero,
  output logic             rsp_err
`ifdef ALU_EXEC_STICKY_EN
  ,
  input  logic             sticky_clr,
  output logic             sticky_overflow,
  output logic             sticky_cout
`endif
);

  exec_state_t state_q, state_d;

  logic [WIDTH-1:0] alu_y;
  logic             alu_cout, alu_overflow, alu_negative, alu_zero;
  logic [WIDTH-1:0] sh_y;
  logic             sh_cout, sh_last;
  logic             accept, go_shift;

  assign accept   = req_valid && (state_q == IDLE);
  // a zero-length shift skips SHIFT and answers with the same latency as a logic op
  assign go_shift = is_shift_op(req_opcode) && (req_b != '0);

  alu #(.WIDTH(WIDTH)) u_alu (
    .opcode   (req_opcode),
    .a        (req_a),
    .b        (req_b),
    .cin      (req_cin),
    .y        (alu_y),
    .cout     (alu_cout),
    .overflow (alu_overflow),
    .negative (alu_negative),
    .zero     (alu_zero)
  );

  alu_iter_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (accept && go_shift),
    .step      (state_q == SHIFT),
    .opcode    (req_opcode),
    .a         (req_a),
    .amount    (req_b),
    .y_next    (sh_y),
    .cout_next (sh_cout),
    .last      (sh_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = go_shift ? SHIFT : RESP;
      end
      SHIFT: if (sh_last) state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // response registers only change when a new result is ready, so they hold
  // the previous response through IDLE and SHIFT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_y        <= '0;
      rsp_cout     <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_negative <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_err      <= 1'b0;
    end else if (accept && !go_shift) begin
      if (is_shift_op(req_opcode)) begin
        rsp_y        <= req_a;
        rsp_cout     <= 1'b0;
        rsp_overflow <= 1'b0;
        rsp_negative <= req_a[WIDTH-1];
        rsp_zero     <= (req_a == '0);
        rsp_err      <= 1'b0;
      end else begin
        rsp_y        <= alu_y;
        rsp_cout     <= alu_cout;
        rsp_overflow <= alu_overflow;
        rsp_negative <= alu_negative;
        rsp_zero     <= alu_zero;
        rsp_err      <= !is_defined_op(req_opcode);
      end
    end else if ((state_q == SHIFT) && sh_last) begin
      rsp_y        <= sh_y;
      rsp_cout     <= sh_cout;
      rsp_overflow <= 1'b0;
      rsp_negative <= sh_y[WIDTH-1];
      rsp_zero     <= (sh_y == '0);
      rsp_err      <= 1'b0;
    end
  end

`ifdef ALU_EXEC_STICKY_EN
  logic rsp_hs;
  assign rsp_hs = rsp_valid && rsp_ready;

  // clear wins over history but not over the flags of a coincident handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_overflow <= 1'b0;
      sticky_cout     <= 1'b0;
    end else if (sticky_clr) begin
      sticky_overflow <= rsp_hs && rsp_overflow;
      sticky_cout     <= rsp_hs && rsp_cout;
    end else if (rsp_hs) begin
      sticky_overflow <= sticky_overflow | rsp_overflow;
      sticky_cout     <= sticky_cout | rsp_cout;
    end
  end
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - self-checking bench for alu_exec_unit
module tb_alu_exec_unit;
  import alu_ops::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [3:0]   req_opcode = 4'h0;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         req_cin = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] rsp_y;
  logic         rsp_cout, rsp_overflow, rsp_negative, rsp_zero, rsp_err;
`ifdef ALU_EXEC_STICKY_EN
  logic         sticky_clr = 1'b0;
  logic         sticky_overflow, sticky_cout;
`endif

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_opcode   (req_opcode),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_cin      (req_cin),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_y        (rsp_y),
    .rsp_cout     (rsp_cout),
    .rsp_overflow (rsp_overflow),
    .rsp_negative (rsp_negative),
    .rsp_zero     (rsp_zero),
    .rsp_err      (rsp_err)
`ifdef ALU_EXEC_STICKY_EN
    ,
    .sticky_clr      (sticky_clr),
    .sticky_overflow (sticky_overflow),
    .sticky_cout     (sticky_cout)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0] y;
    logic       cout;
    logic       ovf;
    logic       neg;
    logic       zero;
    logic       err;
  } resp_t;

  function automatic int sval(input logic [3:0] v);
    return v[3] ? int'(v) - 16 : int'(v);
  endfunction

  // Behavioural reference: plain integer arithmetic on the operation's meaning
  function automatic resp_t model(input logic [3:0] op, input logic [3:0] a,
                                  input logic [3:0] b, input logic cin);
    resp_t o;
    int ua, ub, sa, sb, r, n;
    o  = '0;
    ua = int'(a);
    ub = int'(b);
    sa = sval(a);
    sb = sval(b);
    n  = (ub > W) ? W : ub;
    r  = 0;
    case (op)
      ADD_OP: begin
        r      = ua + ub + int'(cin);
        o.y    = 4'(r % 16);
        o.cout = (r > 15);
        r      = sa + sb + int'(cin);
        o.ovf  = (r > 7) || (r < -8);
      end
      SUB_OP: begin
        o.y    = 4'((ua - ub + 16) % 16);
        o.cout = (ua >= ub);
        r      = sa - sb;
        o.ovf  = (r > 7) || (r < -8);
      end
      NOT_OP: o.y = 4'(15 - ua);
      AND_OP: o.y = a & b;
      OR_OP:  o.y = a | b;
      XOR_OP: o.y = a ^ b;
      LL_SHIFT_OP: begin
        o.y    = 4'((ua << n) % 16);
        o.cout = (n == 0) ? 1'b0 : 1'((ua >> (W - n)) & 1);
      end
      LR_SHIFT_OP: begin
        o.y    = 4'(ua >> n);
        o.cout = (n == 0) ? 1'b0 : 1'((ua >> (n - 1)) & 1);
      end
      AR_SHIFT_OP: begin
        o.y    = 4'((sa >>> n) & 15);
        o.cout = (n == 0) ? 1'b0 : 1'((sa >>> (n - 1)) & 1);
      end
      default: o.err = 1'b1;
    endcase
    o.neg  = o.y[3];
    o.zero = (o.y == 4'h0);
    return o;
  endfunction

  function automatic int lat_of(input logic [3:0] op, input logic [3:0] b);
    if (op == LL_SHIFT_OP || op == LR_SHIFT_OP || op == AR_SHIFT_OP)
      return ((int'(b) > W) ? W : int'(b)) + 1;
    return 1;
  endfunction

  // transaction-level model: one outstanding op, due m_lat cycles after acceptance
  int    cyc = 0;
  int    m_acc = 0;
  int    m_lat = 1;
  logic  m_pending = 1'b0;
  resp_t m_exp = '0;
  resp_t m_last = '0;
  logic  m_valid;

  assign m_valid = m_pending && ((cyc - m_acc + 1) >= m_lat);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pending <= 1'b0;
      m_last    <= '0;
      cyc       <= 0;
    end else begin
      if (m_valid && rsp_ready) begin
        m_pending <= 1'b0;
        m_last    <= m_exp;
      end else if (!m_pending && req_valid) begin
        m_pending <= 1'b1;
        m_acc     <= cyc + 1;
        m_exp     <= model(req_opcode, req_a, req_b, req_cin);
        m_lat     <= lat_of(req_opcode, req_b);
      end
      cyc <= cyc + 1;
    end
  end

  always @(negedge clk) begin : cmp
    resp_t e;
    e = m_valid ? m_exp : m_last;
    chk("cmp req_ready", req_ready, !m_pending);
    chk("cmp rsp_valid", rsp_valid, m_valid);
    chk("cmp rsp_y", rsp_y, e.y);
    chk("cmp rsp_cout", rsp_cout, e.cout);
    chk("cmp rsp_overflow", rsp_overflow, e.ovf);
    chk("cmp rsp_negative", rsp_negative, e.neg);
    chk("cmp rsp_zero", rsp_zero, e.zero);
    chk("cmp rsp_err", rsp_err, e.err);
  end

  // eflags = {cout, overflow, negative, zero, err}
  task automatic run_op(input string nm, input logic [3:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic cin, input int hold,
                        input logic [3:0] ey, input logic [4:0] eflags, input int elat);
    int n;
    int lat;
    logic [3:0] y0;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " req_ready before issue"}, req_ready, 1'b1);
    rsp_ready  = (hold == 0);
    req_valid  = 1'b1;
    req_opcode = op;
    req_a      = a;
    req_b      = b;
    req_cin    = cin;
    lat = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
    end while (!rsp_valid && lat < 30);
    chk({nm, " latency"}, lat, elat);
    chk({nm, " y"}, rsp_y, ey);
    chk({nm, " flags"}, {rsp_cout, rsp_overflow, rsp_negative, rsp_zero, rsp_err}, eflags);
    y0 = rsp_y;
    repeat (hold) begin
      @(negedge clk);
      chk({nm, " hold req_ready"}, req_ready, 1'b0);
      chk({nm, " hold rsp_valid"}, rsp_valid, 1'b1);
      chk({nm, " hold y"}, rsp_y, y0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk({nm, " req_ready after handshake"}, req_ready, 1'b1);
    chk({nm, " rsp_valid after handshake"}, rsp_valid, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset req_ready", req_ready, 1'b1);
    chk("reset rsp_valid", rsp_valid, 1'b0);
    chk("reset rsp_y", rsp_y, 4'h0);
    chk("reset flags", {rsp_cout, rsp_overflow, rsp_negative, rsp_zero, rsp_err}, 5'b00000);
    #2 rst = 1'b0;
    @(negedge clk);

`ifdef ALU_EXEC_STICKY_EN
    chk("sticky reset", {sticky_overflow, sticky_cout}, 2'b00);
    run_op("st add ovf", ADD_OP, 4'h7, 4'h1, 1'b0, 0, 4'h8, 5'b01100, 1);
    chk("sticky after ovf", {sticky_overflow, sticky_cout}, 2'b10);
    run_op("st xor clean", XOR_OP, 4'h3, 4'h1, 1'b0, 0, 4'h2, 5'b00000, 1);
    chk("sticky holds", {sticky_overflow, sticky_cout}, 2'b10);
    sticky_clr = 1'b1;
    run_op("st clr clean", AND_OP, 4'h3, 4'h1, 1'b0, 0, 4'h1, 5'b00000, 1);
    sticky_clr = 1'b0;
    chk("sticky clr+clean", {sticky_overflow, sticky_cout}, 2'b00);
    sticky_clr = 1'b1;
    run_op("st clr cout", ADD_OP, 4'hF, 4'h1, 1'b0, 0, 4'h0, 5'b10010, 1);
    sticky_clr = 1'b0;
    chk("sticky clr+cout", {sticky_overflow, sticky_cout}, 2'b01);
`endif

    run_op("ll 1<<1", LL_SHIFT_OP, 4'h1, 4'h1, 1'b0, 0, 4'h2, 5'b00000, 2);
    run_op("ar 9>>>7", AR_SHIFT_OP, 4'h9, 4'h7, 1'b0, 0, 4'hF, 5'b10100, 5);
    run_op("xor", XOR_OP, 4'hC, 4'hA, 1'b0, 0, 4'h6, 5'b00000, 1);
    run_op("not", NOT_OP, 4'h8, 4'h0, 1'b0, 0, 4'h7, 5'b00000, 1);
    run_op("or hold", OR_OP, 4'hA, 4'h5, 1'b0, 3, 4'hF, 5'b00100, 1);
    run_op("add ovf", ADD_OP, 4'h7, 4'h1, 1'b0, 0, 4'h8, 5'b01100, 1);
    run_op("add cin", ADD_OP, 4'hF, 4'h0, 1'b1, 0, 4'h0, 5'b10010, 1);
    run_op("sub borrow", SUB_OP, 4'h0, 4'h1, 1'b0, 0, 4'hF, 5'b00100, 1);
    run_op("sub", SUB_OP, 4'h5, 4'h3, 1'b0, 0, 4'h2, 5'b10000, 1);
    run_op("ll count0", LL_SHIFT_OP, 4'h5, 4'h0, 1'b0, 0, 4'h5, 5'b00000, 1);
    run_op("ll out", LL_SHIFT_OP, 4'h8, 4'h1, 1'b0, 0, 4'h0, 5'b10010, 2);
    run_op("lr cap", LR_SHIFT_OP, 4'h6, 4'h9, 1'b0, 0, 4'h0, 5'b00010, 5);
    run_op("lr 2", LR_SHIFT_OP, 4'h6, 4'h2, 1'b0, 2, 4'h1, 5'b10000, 3);
    run_op("undef", 4'hF, 4'h5, 4'h3, 1'b1, 0, 4'h0, 5'b00011, 1);

    // reset pulsed during the second SHIFT cycle discards the operation
    req_valid  = 1'b1;
    req_opcode = LR_SHIFT_OP;
    req_a      = 4'h8;
    req_b      = 4'h3;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst-mid shift req_ready", req_ready, 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;
    #6 rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("rst-mid no rsp_valid", rsp_valid, 1'b0);
      chk("rst-mid req_ready", req_ready, 1'b1);
      chk("rst-mid rsp_y", rsp_y, 4'h0);
    end
    run_op("and after rst", AND_OP, 4'hC, 4'hA, 1'b0, 0, 4'h8, 5'b00100, 1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
